// File: rtl/cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl -- coprocessor-0 register file and interrupt controller for the
// single-cycle CPU.
//
// Holds status (sta), cause (cau), epc, an interrupt mask (imask) and the
// pending register (ipend). Rising edges on irq set pending bits, and the
// controller raises one combined request (intr) to the control generator.
// Exception, interrupt-acknowledge, eret and mtc0 updates are applied on the
// rising clock edge in which the control generator asserts them.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   irq[NIRQ-1:0]            external interrupt lines, rising-edge significant
//   intr                     |(ipend & imask)
//   inta, exc, eret, mtc0    control strobes from the control generator
//   wsta, wcau, wepc         write enables for sta / cau / epc
//   rd, wdata                c0 register number and mtc0 data
//   cause_in, epc_in         values saved when an exception is taken
//   sta, cau, epc            architectural registers
//   rdata                    c0 read mux: 10 imask, 11 ipend, 12 sta, 13 cau,
//                            14 epc, all other numbers read 0
//
// Build option: define CP0_IRQ_SYNC_EN to put a two-flop synchronizer in front
// of the edge detector (irq edge -> intr in 3 cycles instead of 1). Without it,
// irq must be synchronous to clk.
// -----------------------------------------------------------------------------
module cp0_irq_ctrl #(
  parameter int          NIRQ      = 4,
  parameter logic [31:0] STA_RST   = 32'h0000000F,
  parameter logic [7:0]  IMASK_RST = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  output logic            intr,
  input  logic            inta,
  input  logic            exc,
  input  logic            eret,
  input  logic            mtc0,
  input  logic            wsta,
  input  logic            wcau,
  input  logic            wepc,
  input  logic [4:0]      rd,
  input  logic [31:0]     wdata,
  input  logic [31:0]     cause_in,
  input  logic [31:0]     epc_in,
  output logic [31:0]     sta,
  output logic [31:0]     cau,
  output logic [31:0]     epc,
  output logic [31:0]     rdata
);

  localparam logic [4:0] RD_IMASK = 5'd10;
  localparam logic [4:0] RD_IPEND = 5'd11;
  localparam logic [4:0] RD_STA   = 5'd12;
  localparam logic [4:0] RD_CAU   = 5'd13;
  localparam logic [4:0] RD_EPC   = 5'd14;

  logic [31:0]     sta_q, sta_d;
  logic [31:0]     cau_q, cau_d;
  logic [31:0]     epc_q, epc_d;
  logic [7:0]      imask_q, imask_d;
  logic [NIRQ-1:0] ipend_q, ipend_d;
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] irq_s;

  logic [NIRQ-1:0] irq_rise;
  logic [NIRQ-1:0] pend_masked;
  logic [NIRQ-1:0] ack_oh;
  logic [2:0]      ack_id;
  logic [2:0]      cau_id;
  logic            ack;
  logic            wr_c0;

`ifdef CP0_IRQ_SYNC_EN
  logic [NIRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  assign irq_rise    = irq_s & ~irq_prev_q;
  assign pend_masked = ipend_q & imask_q[NIRQ-1:0];
  assign intr        = |pend_masked;
  assign ack         = exc & inta;
  // An exception in the same cycle wins over any mtc0 write.
  assign wr_c0       = mtc0 & ~exc;

  // Lowest-index enabled pending line wins; scanning downwards lets the last
  // hit (smallest index) overwrite earlier ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ack_oh = '0;
    ack_id = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend_masked[i]) begin
        ack_oh    = '0;
        ack_oh[i] = 1'b1;
        ack_id    = 3'(i);
      end
    end
  end

  assign cau_id = inta ? ack_id : cau_q[10:8];

  always_comb begin
    sta_d   = sta_q;
    cau_d   = cau_q;
    epc_d   = epc_q;
    imask_d = imask_q;
    ipend_d = ipend_q;

    if (exc && wsta)                      sta_d = {sta_q[27:0], 4'b0};
    else if (eret && wsta)                sta_d = {4'b0, sta_q[31:4]};
    else if (wr_c0 && wsta && rd == RD_STA) sta_d = wdata;

    if (exc && wcau)                      cau_d = {cause_in[31:11], cau_id, cause_in[7:0]};
    else if (wr_c0 && wcau && rd == RD_CAU) cau_d = wdata;

    if (exc && wepc)                      epc_d = epc_in;
    else if (wr_c0 && wepc && rd == RD_EPC) epc_d = wdata;

    if (wr_c0 && rd == RD_IMASK) imask_d = wdata[7:0];

    if (ack)                     ipend_d = ipend_d & ~ack_oh;
    if (wr_c0 && rd == RD_IPEND) ipend_d = ipend_d & ~wdata[NIRQ-1:0];
    // New edges are applied last so a same-cycle set beats any clear.
    ipend_d = ipend_d | irq_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      sta_q      <= STA_RST;
      cau_q      <= '0;
      epc_q      <= '0;
      imask_q    <= IMASK_RST;
      ipend_q    <= '0;
      irq_prev_q <= '0;
    end else begin
      sta_q      <= sta_d;
      cau_q      <= cau_d;
      epc_q      <= epc_d;
      imask_q    <= imask_d;
      ipend_q    <= ipend_d;
      irq_prev_q <= irq_s;
    end
  end

  assign sta = sta_q;
  assign cau = cau_q;
  assign epc = epc_q;

  always_comb begin
    rdata = '0;
    case (rd)
      RD_IMASK: rdata = {24'b0, imask_q};
      RD_IPEND: rdata = {{(32 - NIRQ){1'b0}}, ipend_q};
      RD_STA:   rdata = sta_q;
      RD_CAU:   rdata = cau_q;
      RD_EPC:   rdata = epc_q;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_irq_ctrl -- self-checking bench for cp0_irq_ctrl (NIRQ = 4).
// A behavioural model of the c0 registers tracks expected state; directed
// scenarios are followed by a randomized phase and a mid-run async reset.
// -----------------------------------------------------------------------------
module tb_cp0_irq_ctrl;

  localparam int NIRQ = 4;
`ifdef CP0_IRQ_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq;
  logic            intr;
  logic            inta, exc, eret, mtc0, wsta, wcau, wepc;
  logic [4:0]      rd;
  logic [31:0]     wdata, cause_in, epc_in;
  logic [31:0]     sta, cau, epc, rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0]     m_sta, m_cau, m_epc;
  logic [7:0]      m_imask;
  logic [NIRQ-1:0] m_ipend, m_prev, m_s1, m_s2;
  // Next-state values computed before each clock edge.
  logic [31:0]     n_sta, n_cau, n_epc;
  logic [7:0]      n_imask;
  logic [NIRQ-1:0] n_ipend, n_prev, n_s1, n_s2;

  cp0_irq_ctrl #(.NIRQ(NIRQ), .STA_RST(32'h0000000F), .IMASK_RST(8'hFF)) dut (
    .clk(clk), .rst(rst), .irq(irq), .intr(intr), .inta(inta), .exc(exc),
    .eret(eret), .mtc0(mtc0), .wsta(wsta), .wcau(wcau), .wepc(wepc), .rd(rd),
    .wdata(wdata), .cause_in(cause_in), .epc_in(epc_in), .sta(sta), .cau(cau),
    .epc(epc), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_intr();
    return |(m_ipend & m_imask[NIRQ-1:0]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd10:   return {24'b0, m_imask};
      5'd11:   return {28'b0, m_ipend};
      5'd12:   return m_sta;
      5'd13:   return m_cau;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_sta = 32'h0000000F; m_cau = '0; m_epc = '0; m_imask = 8'hFF;
    m_ipend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
  endtask

  // Apply the register rules to the current inputs and model state.
  task automatic model_next();
    logic [NIRQ-1:0] seen, rise, pm, lsb, tmp;
    int id;
    seen = (SYNC_EXTRA > 0) ? m_s2 : irq;
    rise = seen & ~m_prev;
    pm   = m_ipend & m_imask[NIRQ-1:0];
    lsb  = pm & (~pm + 1'b1);  // isolate lowest set bit
    id = 0;
    tmp = lsb;
    while (tmp > 1) begin tmp = tmp >> 1; id++; end

    n_sta = m_sta;
    if (exc && wsta)                    n_sta = m_sta << 4;
    else if (eret && wsta)              n_sta = m_sta >> 4;
    else if (mtc0 && wsta && rd == 12)  n_sta = wdata;

    n_cau = m_cau;
    if (exc && wcau) begin
      n_cau = cause_in;
      n_cau[10:8] = inta ? 3'(id) : m_cau[10:8];
    end else if (mtc0 && wcau && rd == 13) n_cau = wdata;

    n_epc = m_epc;
    if (exc && wepc)                    n_epc = epc_in;
    else if (mtc0 && wepc && rd == 14)  n_epc = wdata;

    n_imask = m_imask;
    if (mtc0 && !exc && rd == 10) n_imask = wdata[7:0];

    n_ipend = m_ipend;
    if (exc && inta)               n_ipend = n_ipend & ~lsb;
    if (mtc0 && !exc && rd == 11)  n_ipend = n_ipend & ~wdata[NIRQ-1:0];
    n_ipend = n_ipend | rise;

    n_prev = seen;
    n_s1   = irq;
    n_s2   = m_s1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".sta"},   sta,   m_sta);
    check({tag, ".cau"},   cau,   m_cau);
    check({tag, ".epc"},   epc,   m_epc);
    check({tag, ".intr"},  {31'b0, intr}, {31'b0, m_intr()});
    check({tag, ".rdata"}, rdata, m_read(rd));
  endtask

  // One clock: model evaluates with pre-edge inputs, outputs sampled 1 after the edge.
  task automatic cycle(input string tag);
    model_next();
    @(posedge clk);
    m_sta = n_sta; m_cau = n_cau; m_epc = n_epc; m_imask = n_imask;
    m_ipend = n_ipend; m_prev = n_prev; m_s1 = n_s1; m_s2 = n_s2;
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    inta = 0; exc = 0; eret = 0; mtc0 = 0; wsta = 0; wcau = 0; wepc = 0;
    wdata = '0; cause_in = '0; epc_in = '0;
  endtask

  // One-cycle irq pulse followed by enough cycles for it to reach ipend.
  task automatic pulse(input logic [NIRQ-1:0] lines);
    idle();
    irq = lines;
    cycle("pulse");
    irq = '0;
    repeat (SYNC_EXTRA) cycle("settle");
  endtask

  task automatic mtc0_wr(input logic [4:0] r, input logic [31:0] d);
    idle();
    mtc0 = 1; rd = r; wdata = d;
    wsta = (r == 12); wcau = (r == 13); wepc = (r == 14);
    cycle("mtc0");
    idle();
  endtask

  initial begin
    rst = 1'b1;
    irq = '0;
    rd  = 5'd10;
    idle();
    model_reset();
    #1;
    check("rst_sta", sta, 32'h0000000F);
    check("rst_cau", cau, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_intr", {31'b0, intr}, 32'h0);
    check("rst_imask", rdata, 32'h000000FF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // irq[2] pulse, then full exception/acknowledge.
    pulse(4'b0100);
    check("irq2_intr", {31'b0, intr}, 32'h1);
    exc = 1; inta = 1; wsta = 1; wcau = 1; wepc = 1; epc_in = 32'h40; rd = 5'd11;
    cycle("ack2");
    idle();
    check("ack2_cau",   cau,   32'h00000200);
    check("ack2_sta",   sta,   32'h000000F0);
    check("ack2_epc",   epc,   32'h00000040);
    check("ack2_intr",  {31'b0, intr}, 32'h0);
    check("ack2_ipend", rdata, 32'h0);

    // irq[1] and irq[3] together: two acks in priority order.
    pulse(4'b1010);
    exc = 1; inta = 1; wcau = 1; rd = 5'd11;
    cycle("ack_a");
    check("ack_a_id",    {29'b0, cau[10:8]}, 32'd1);
    check("ack_a_ipend", rdata, 32'h8);
    cycle("ack_b");
    idle();
    check("ack_b_id",    {29'b0, cau[10:8]}, 32'd3);
    check("ack_b_ipend", rdata, 32'h0);

    // Masked interrupt, unmask, then write-1-to-clear.
    mtc0_wr(5'd10, 32'h0);
    pulse(4'b0001);
    rd = 5'd11; #1;
    check("mask_ipend", rdata, 32'h1);
    check("mask_intr",  {31'b0, intr}, 32'h0);
    mtc0_wr(5'd10, 32'h1);
    check("unmask_intr", {31'b0, intr}, 32'h1);
    mtc0_wr(5'd11, 32'h1);
    check("w1c_ipend", rdata, 32'h0);
    check("w1c_intr",  {31'b0, intr}, 32'h0);
    mtc0_wr(5'd10, 32'hFF);

    // eret restore, then exc shift beats a same-cycle mtc0 to sta.
    rd = 5'd12; #1;
    check("sta_pre", rdata, 32'h000000F0);
    eret = 1; wsta = 1;
    cycle("eret");
    idle();
    check("eret_sta", sta, 32'h0000000F);
    exc = 1; mtc0 = 1; wsta = 1; rd = 5'd12; wdata = 32'h5;
    cycle("exc_vs_mtc0");
    idle();
    check("exc_wins_sta", sta, 32'h000000F0);
    eret = 1; wsta = 1;
    cycle("eret2");
    idle();

    // Ack of irq[0] while a fresh irq[0] edge arrives: bit stays pending.
    pulse(4'b0001);
    cycle("gap");
    irq = 4'b0001;
    repeat (SYNC_EXTRA) cycle("hold");
    exc = 1; inta = 1; rd = 5'd11;
    cycle("ack_edge");
    idle();
    irq = '0;
    check("ack_edge_ipend", rdata, 32'h1);
    check("ack_edge_intr",  {31'b0, intr}, 32'h1);

    // Randomized phase.
    for (int n = 0; n < 300; n++) begin
      idle();
      irq  = 4'($urandom);
      exc  = ($urandom_range(0, 7) == 0);
      inta = exc && m_intr() && $urandom_range(0, 1);
      eret = !exc && ($urandom_range(0, 9) == 0);
      mtc0 = ($urandom_range(0, 3) == 0);
      wsta = $urandom_range(0, 1);
      wcau = $urandom_range(0, 1);
      wepc = $urandom_range(0, 1);
      rd   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(10, 14));
      wdata    = $urandom;
      cause_in = $urandom;
      epc_in   = $urandom;
      cycle("rand");
    end

    // Asynchronous reset mid-run, checked before any clock edge.
    idle();
    irq = '0;
    rd  = 5'd11;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("mrst_sta",   sta,   32'h0000000F);
    check("mrst_cau",   cau,   32'h0);
    check("mrst_epc",   epc,   32'h0);
    check("mrst_ipend", rdata, 32'h0);
    check("mrst_intr",  {31'b0, intr}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
